// File: rtl/mem2io_if.sv
// Bundle of CPU, SRAM and IO signals around the mem2io bridge.
// The slave modport is the bridge's view of the bundle.
interface mem2io_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20
);
  logic              CPU_REQ;
  logic              CPU_WE;
  logic [ADDR_W-1:0] CPU_ADDR;
  logic [DATA_W-1:0] Data_from_CPU;
  logic              CPU_ACK;
  logic [DATA_W-1:0] Data_to_CPU;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic [DATA_W-1:0] Data_to_SRAM;
  logic [DATA_W-1:0] Data_from_SRAM;
  logic              SRAM_CE_N;
  logic              SRAM_OE_N;
  logic              SRAM_WE_N;
  logic              SRAM_DRIVE;
  logic [DATA_W-1:0] Switches;
  logic [DATA_W-1:0] Hex_data;

  modport slave (
    input  CPU_REQ, CPU_WE, CPU_ADDR, Data_from_CPU, Data_from_SRAM, Switches,
    output CPU_ACK, Data_to_CPU, SRAM_ADDR, Data_to_SRAM,
           SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DRIVE, Hex_data
  );

  modport master (
    output CPU_REQ, CPU_WE, CPU_ADDR, Data_from_CPU, Data_from_SRAM, Switches,
    input  CPU_ACK, Data_to_CPU, SRAM_ADDR, Data_to_SRAM,
           SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DRIVE, Hex_data
  );
endinterface

// File: rtl/mem2io_bridge.sv
// CPU request bridge to an asynchronous SRAM with wait states, plus one
// memory-mapped IO word (switches in, hex register out).
module mem2io_bridge #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 20,
  parameter int                WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0] IO_ADDR     = '1
) (
  input  logic     Clk,
  input  logic     Reset,
  mem2io_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t     state, state_nxt;
  logic       we_q;
  logic [3:0] wait_cnt;
  logic       is_io;

  assign is_io = (bus.CPU_ADDR == IO_ADDR);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.CPU_REQ) state_nxt = is_io ? DONE : ACCESS;
      ACCESS:  if (wait_cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are decoded from state so an asynchronous reset drops them at once.
  always_comb begin
    bus.SRAM_CE_N  = 1'b1;
    bus.SRAM_OE_N  = 1'b1;
    bus.SRAM_WE_N  = 1'b1;
    bus.SRAM_DRIVE = 1'b0;
    bus.CPU_ACK    = 1'b0;
    case (state)
      ACCESS: begin
        bus.SRAM_CE_N  = 1'b0;
        bus.SRAM_OE_N  = we_q;
        bus.SRAM_WE_N  = ~we_q;
        bus.SRAM_DRIVE = we_q;
      end
      DONE:    bus.CPU_ACK = 1'b1;
      default: ;
    endcase
  end

  // Request fields are only captured in IDLE; later changes are ignored.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      we_q             <= 1'b0;
      wait_cnt         <= 4'd0;
      bus.SRAM_ADDR    <= '0;
      bus.Data_to_SRAM <= '0;
      bus.Data_to_CPU  <= '0;
      bus.Hex_data     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.CPU_REQ) begin
            if (is_io) begin
              if (bus.CPU_WE) bus.Hex_data    <= bus.Data_from_CPU;
              else            bus.Data_to_CPU <= bus.Switches;
            end else begin
              bus.SRAM_ADDR    <= bus.CPU_ADDR;
              bus.Data_to_SRAM <= bus.Data_from_CPU;
              we_q             <= bus.CPU_WE;
              wait_cnt         <= 4'(WAIT_STATES);
            end
          end
        end
        ACCESS: begin
          if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
          else if (!we_q)       bus.Data_to_CPU <= bus.Data_from_SRAM;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem2io_bridge.sv
// Directed bench for mem2io_bridge: one instance with one wait state, one
// with none for the back-to-back sequence.
module tb_mem2io_bridge;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   total = 0;
  int   passed = 0;

  always #5 Clk = ~Clk;

  mem2io_if #(.DATA_W(16), .ADDR_W(20)) b1 ();
  mem2io_if #(.DATA_W(16), .ADDR_W(20)) b0 ();

  mem2io_bridge #(.DATA_W(16), .ADDR_W(20), .WAIT_STATES(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .bus(b1.slave));
  mem2io_bridge #(.DATA_W(16), .ADDR_W(20), .WAIT_STATES(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .bus(b0.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic strobes1(input string tag, input logic [3:0] exp);
    check(tag, {b1.SRAM_CE_N, b1.SRAM_OE_N, b1.SRAM_WE_N, b1.SRAM_DRIVE}, {28'd0, exp});
  endtask

  initial begin
    b1.CPU_REQ = 0; b1.CPU_WE = 0; b1.CPU_ADDR = '0; b1.Data_from_CPU = '0;
    b1.Data_from_SRAM = '0; b1.Switches = '0;
    b0.CPU_REQ = 0; b0.CPU_WE = 0; b0.CPU_ADDR = '0; b0.Data_from_CPU = '0;
    b0.Data_from_SRAM = '0; b0.Switches = '0;
    #2 Reset = 1'b0;
    #1;
    check("rst_ack", b1.CPU_ACK, 0);
    strobes1("rst_strobes", 4'b1110);
    check("rst_sram_addr", b1.SRAM_ADDR, 0);
    check("rst_dout", b1.Data_to_CPU, 0);
    check("rst_hex", b1.Hex_data, 0);
    tick();
    Reset = 1'b1;

    // SRAM write 0xBEEF to 0x00010, one wait state
    b1.CPU_REQ = 1; b1.CPU_WE = 1; b1.CPU_ADDR = 20'h00010; b1.Data_from_CPU = 16'hBEEF;
    tick();
    b1.CPU_ADDR = 20'h00055; b1.Data_from_CPU = 16'h0000; b1.CPU_WE = 0;
    strobes1("wr_c1_strobes", 4'b0101);
    check("wr_c1_addr", b1.SRAM_ADDR, 32'h00010);
    check("wr_c1_data", b1.Data_to_SRAM, 32'hBEEF);
    check("wr_c1_ack", b1.CPU_ACK, 0);
    tick();
    strobes1("wr_c2_strobes", 4'b0101);
    check("wr_c2_addr_held", b1.SRAM_ADDR, 32'h00010);
    check("wr_c2_ack", b1.CPU_ACK, 0);
    tick();
    check("wr_c3_ack", b1.CPU_ACK, 1);
    strobes1("wr_c3_strobes", 4'b1110);
    check("wr_dout_unchanged", b1.Data_to_CPU, 0);
    b1.CPU_REQ = 0;
    tick();
    check("wr_idle_ack", b1.CPU_ACK, 0);

    // SRAM read 0x00010 returning 0xBEEF
    b1.CPU_REQ = 1; b1.CPU_WE = 0; b1.CPU_ADDR = 20'h00010; b1.Data_from_SRAM = 16'hBEEF;
    tick();
    strobes1("rd_c1_strobes", 4'b0010);
    check("rd_c1_dout", b1.Data_to_CPU, 0);
    tick();
    strobes1("rd_c2_strobes", 4'b0010);
    check("rd_c2_ack", b1.CPU_ACK, 0);
    tick();
    check("rd_c3_ack", b1.CPU_ACK, 1);
    check("rd_c3_dout", b1.Data_to_CPU, 32'hBEEF);
    b1.CPU_REQ = 0; b1.Data_from_SRAM = 16'h0000;
    tick();
    check("rd_idle_ack", b1.CPU_ACK, 0);
    check("rd_dout_hold", b1.Data_to_CPU, 32'hBEEF);

    // IO write 0x1234 to 0xFFFFF
    b1.CPU_REQ = 1; b1.CPU_WE = 1; b1.CPU_ADDR = 20'hFFFFF; b1.Data_from_CPU = 16'h1234;
    tick();
    check("iow_ack", b1.CPU_ACK, 1);
    check("iow_hex", b1.Hex_data, 32'h1234);
    strobes1("iow_strobes", 4'b1110);
    check("iow_dout_unchanged", b1.Data_to_CPU, 32'hBEEF);
    b1.CPU_REQ = 0;
    tick();

    // IO read 0xFFFFF with switches 0x00A5
    b1.CPU_REQ = 1; b1.CPU_WE = 0; b1.CPU_ADDR = 20'hFFFFF; b1.Switches = 16'h00A5;
    tick();
    check("ior_ack", b1.CPU_ACK, 1);
    check("ior_dout", b1.Data_to_CPU, 32'h00A5);
    check("ior_hex_unchanged", b1.Hex_data, 32'h1234);
    strobes1("ior_strobes", 4'b1110);
    b1.CPU_REQ = 0;
    tick();

    // Back-to-back reads with no wait states: ACKs at cycles 2, 5, 8
    b0.CPU_REQ = 1; b0.CPU_WE = 0; b0.CPU_ADDR = 20'h00020; b0.Data_from_SRAM = 16'h1111;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("b2b_ack_c%0d", c), b0.CPU_ACK, (c == 2 || c == 5 || c == 8) ? 1 : 0);
    end
    check("b2b_dout", b0.Data_to_CPU, 32'h1111);
    b0.CPU_REQ = 0;
    tick();
    check("b2b_end_ack", b0.CPU_ACK, 0);

    // Reset during the second ACCESS cycle of a read
    b1.CPU_REQ = 1; b1.CPU_WE = 0; b1.CPU_ADDR = 20'h00030; b1.Data_from_SRAM = 16'hCAFE;
    tick();
    tick();
    strobes1("abort_pre_strobes", 4'b0010);
    #1 Reset = 1'b0;
    #1;
    strobes1("abort_strobes", 4'b1110);
    check("abort_ack", b1.CPU_ACK, 0);
    check("abort_sram_addr", b1.SRAM_ADDR, 0);
    check("abort_sram_data", b1.Data_to_SRAM, 0);
    check("abort_dout", b1.Data_to_CPU, 0);
    check("abort_hex", b1.Hex_data, 0);
    tick();
    check("abort_held_ack", b1.CPU_ACK, 0);
    b1.CPU_ADDR = 20'hFFFFF; b1.Switches = 16'h5A5A;
    Reset = 1'b1;
    tick();
    check("post_rst_ack", b1.CPU_ACK, 1);
    check("post_rst_dout", b1.Data_to_CPU, 32'h5A5A);
    b1.CPU_REQ = 0;
    tick();
    check("post_rst_idle_ack", b1.CPU_ACK, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem2io_bridge.md
MEM2IO_BRIDGE -- requirements
Module: mem2io_bridge

Interface
REQ-001 Parameter: DATA_W, default 16, data bus width for CPU, SRAM, switches and hex register.
REQ-002 Parameter: ADDR_W, default 20, address width.
REQ-003 Parameter: WAIT_STATES, default 1, extra SRAM access cycles; legal range 0..15.
REQ-004 Parameter: IO_ADDR, default all ones of ADDR_W, the single memory-mapped IO address.
REQ-005 Clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 Reset  in  1  asynchronous, active-low reset.
REQ-007 CPU_REQ  in  1  transaction request; held high until CPU_ACK.
REQ-008 CPU_WE  in  1  1 = write, 0 = read; sampled with CPU_REQ.
REQ-009 CPU_ADDR  in  ADDR_W  transaction address.
REQ-010 Data_from_CPU  in  DATA_W  write data.
REQ-011 CPU_ACK  out  1  one-cycle completion pulse.
REQ-012 Data_to_CPU  out  DATA_W  registered read data.
REQ-013 SRAM_ADDR  out  ADDR_W  registered SRAM address.
REQ-014 Data_to_SRAM  out  DATA_W  registered SRAM write data.
REQ-015 Data_from_SRAM  in  DATA_W  SRAM read data.
REQ-016 SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  out  1 each  active-low SRAM strobes.
REQ-017 SRAM_DRIVE  out  1  1 = Data_to_SRAM drives the SRAM bus.
REQ-018 Switches  in  DATA_W  IO read source.
REQ-019 Hex_data  out  DATA_W  IO write register.

Function
REQ-020 FSM states: IDLE, ACCESS, DONE; the bridge SHALL leave IDLE only when CPU_REQ=1 in IDLE.
REQ-021 IDLE with CPU_REQ=1 and CPU_ADDR!=IO_ADDR: capture address, data and WE into SRAM_ADDR, Data_to_SRAM and an internal WE flag; load wait counter with WAIT_STATES; go to ACCESS.
REQ-022 ACCESS: SRAM_CE_N=0; read: SRAM_OE_N=0, SRAM_WE_N=1, SRAM_DRIVE=0; write: SRAM_OE_N=1, SRAM_WE_N=0, SRAM_DRIVE=1.
REQ-023 ACCESS with counter>0: decrement counter; with counter=0: go to DONE, and on a read latch Data_from_SRAM into Data_to_CPU on that edge.
REQ-024 ACCESS SHALL last exactly WAIT_STATES+1 cycles; WAIT_STATES=0 gives one ACCESS cycle.
REQ-025 IDLE with CPU_REQ=1 and CPU_ADDR=IO_ADDR: no SRAM strobe asserted; go directly to DONE.
REQ-026 IO write: Hex_data<=Data_from_CPU on the IDLE->DONE edge.
REQ-027 IO read: Data_to_CPU<=Switches sampled on the IDLE->DONE edge.
REQ-028 DONE: CPU_ACK=1 for exactly that cycle; all SRAM strobes inactive; next state IDLE unconditionally.
REQ-029 CPU_ACK SHALL be 0 in every state other than DONE.
REQ-030 Latency, request sampled in IDLE to CPU_ACK high: SRAM access WAIT_STATES+2 cycles; IO access 1 cycle.
REQ-031 CPU_REQ still high in IDLE after DONE SHALL start a new transaction (back-to-back, one IDLE cycle between ACKs).
REQ-032 CPU_REQ, CPU_WE, CPU_ADDR and Data_from_CPU changes outside IDLE SHALL be ignored.
REQ-033 Data_to_CPU SHALL hold its value until the next completed read; writes SHALL not alter it.
REQ-034 Hex_data SHALL change only on an IO write.
REQ-035 In IDLE and DONE: SRAM_CE_N=SRAM_OE_N=SRAM_WE_N=1 and SRAM_DRIVE=0.

Reset
REQ-036 Reset=0 SHALL immediately, without a clock edge, force: state IDLE, CPU_ACK=0, strobes=1, SRAM_DRIVE=0, SRAM_ADDR=0, Data_to_SRAM=0, Data_to_CPU=0, Hex_data=0, wait counter=0.
REQ-037 Reset asserted mid-ACCESS SHALL abort the transaction with no CPU_ACK; after release the bridge SHALL resume in IDLE.
REQ-038 First transaction SHALL be accepted on the first rising edge after Reset deasserts.

Verification
REQ-039 WAIT_STATES=1, write 0xBEEF to 0x00010: SRAM_WE_N=0 and SRAM_DRIVE=1 for 2 cycles, SRAM_ADDR=0x00010, Data_to_SRAM=0xBEEF, CPU_ACK high at cycle 3 for 1 cycle.
REQ-040 WAIT_STATES=1, read 0x00010 with Data_from_SRAM=0xBEEF: SRAM_OE_N=0 for 2 cycles, SRAM_DRIVE=0, Data_to_CPU=0xBEEF when CPU_ACK=1.
REQ-041 IO write 0x1234 to 0xFFFFF: Hex_data=0x1234 and CPU_ACK=1 one cycle later; SRAM_CE_N stays 1.
REQ-042 IO read 0xFFFFF with Switches=0x00A5: Data_to_CPU=0x00A5 with CPU_ACK one cycle later; Hex_data unchanged.
REQ-043 CPU_REQ held high for 3 SRAM reads, WAIT_STATES=0: CPU_ACK at cycles 2, 5, 8.
REQ-044 Reset=0 during second ACCESS cycle: strobes go 1 and state goes IDLE immediately, no CPU_ACK, all registers 0.
